// File: rtl/dev_bus_arbiter.sv
// rtl/dev_bus_arbiter.sv - two-master round-robin arbiter driving a registered device bus
module dev_bus_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic        m1_req,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic [31:0] rdata,
  output logic [29:0] PrAddr,
  output logic [31:0] PrWD,
  output logic        PrWE,
  output logic [3:0]  PrBE,
  input  logic [31:0] PrRD
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       last_gnt;   // 1 when master 1 received the most recent grant
  logic       any_req;
  logic       pick_m1;
  logic       do_grant;

  assign any_req = m0_req | m1_req;
  // Master 1 wins alone, or under contention when master 0 was granted last.
  assign pick_m1 = m1_req & (~m0_req | ~last_gnt);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; arbitration is only open in IDLE and RESP.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          do_grant  = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (any_req) begin
          do_grant  = 1'b1;
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered grant, completion, device-bus and read-data outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 4'd0;
      last_gnt <= 1'b1;
      m0_gnt   <= 1'b0;
      m1_gnt   <= 1'b0;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      rdata    <= 32'd0;
      PrAddr   <= 30'd0;
      PrWD     <= 32'd0;
      PrWE     <= 1'b0;
      PrBE     <= 4'd0;
    end else begin
      // Strobe and completion are single-cycle pulses unless re-asserted below.
      PrWE    <= 1'b0;
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      if (do_grant) begin
        m0_gnt   <= ~pick_m1;
        m1_gnt   <= pick_m1;
        last_gnt <= pick_m1;
        cnt      <= CNT_LOAD;
        PrAddr   <= pick_m1 ? m1_addr : m0_addr;
        PrWD     <= pick_m1 ? m1_wd   : m0_wd;
        PrBE     <= pick_m1 ? m1_be   : m0_be;
        PrWE     <= pick_m1 ? m1_we   : m0_we;
      end else begin
        case (state)
          ACCESS: begin
            if (cnt == 4'd0) begin
              rdata   <= PrRD;
              m0_done <= m0_gnt;
              m1_done <= m1_gnt;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          RESP: begin
            m0_gnt <= 1'b0;
            m1_gnt <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
